idct4_da: RTL and testbench

IDCT4_DA -- requirements
Module: idct4_da

---
 rtl/idct_pkg.sv | 24 ++
 rtl/idct_da_rom.sv | 48 ++++
 rtl/idct4_da.sv | 160 ++++++++++++++++
 tb/tb_idct4_da.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// -----------------------------------------------------------------------------
// idct_pkg
// Shared definitions for the 4-point distributed-arithmetic IDCT:
//   - Q2.14 cosine constants C2, C4, C6
//   - FSM state encoding (IDLE, SHIFT, DONE)
//   - ROM word and accumulator widths
// No ports (package).
// -----------------------------------------------------------------------------
package idct_pkg;

  localparam int ROM_W = 17;
  localparam int ACC_W = 34;

  localparam logic signed [ROM_W-1:0] C2 = 17'sd15137;
  localparam logic signed [ROM_W-1:0] C4 = 17'sd11585;
  localparam logic signed [ROM_W-1:0] C6 = 17'sd6269;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/idct_da_rom.sv
// -----------------------------------------------------------------------------
// idct_da_rom
// Combinational distributed-arithmetic partial-sum table for one IDCT row.
// The word is the sum of the row coefficients M[row][k] whose coefficient bit
// is set in the address.
// Ports:
//   row_i  [1:0]  output row select (0..3)
//   addr_i [3:0]  {X0 bit, X1 bit, X2 bit, X3 bit}
//   word_o [16:0] signed partial sum (Q2.14)
// -----------------------------------------------------------------------------
module idct_da_rom
  import idct_pkg::*;
(
  input  logic [1:0]              row_i,
  input  logic [3:0]              addr_i,
  output logic signed [ROM_W-1:0] word_o
);

  logic signed [ROM_W-1:0] k0, k1, k2, k3;

  always_comb begin
    k0 = C4;
    k1 = C2;
    k2 = C4;
    k3 = C6;
    case (row_i)
      2'd1: begin
        k1 = C6;
        k2 = -C4;
        k3 = -C2;
      end
      2'd2: begin
        k1 = -C6;
        k2 = -C4;
        k3 = C2;
      end
      2'd3: begin
        k1 = -C2;
        k3 = -C6;
      end
      default: ;
    endcase
    // Largest magnitude (c4+c2+c4+c6 = 44576) fits the 17-bit signed word.
    word_o = (addr_i[3] ? k0 : 17'sd0) + (addr_i[2] ? k1 : 17'sd0)
           + (addr_i[1] ? k2 : 17'sd0) + (addr_i[0] ? k3 : 17'sd0);
  end

endmodule

// File: rtl/idct4_da.sv
// -----------------------------------------------------------------------------
// idct4_da
// 4-point inverse DCT using bit-serial (LSB-first) distributed arithmetic.
// One coefficient bit per cycle addresses four row ROMs; the ROM words are
// shifted by the bit weight and accumulated, the sign bit weight being
// subtracted. The result is floor(acc / 2^FRAC), narrowed to DW bits.
// Optional build macro: IDCT_SAT_EN -- saturate outputs instead of wrapping.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input vector handshake (ready only in IDLE)
//   x0..x3  [DW-1:0]      signed DCT coefficients
//   out_valid / out_ready result handshake (valid only in DONE)
//   y0..y3  [DW-1:0]      signed reconstructed samples
// -----------------------------------------------------------------------------
module idct4_da
  import idct_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] y2,
  output logic [DW-1:0] y3
);

  localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]           xs_q [4];
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_d [4];
  logic [DW-1:0]           y_q [4];
  logic [DW-1:0]           y_d [4];
  logic signed [ROM_W-1:0] rom_w [4];
  logic [3:0]              addr;
  logic                    accept;
  logic                    last_bit;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [ROM_W-1:0] w);
    return {{(ACC_W-ROM_W){w[ROM_W-1]}}, w};
  endfunction

  // Floor division by 2^FRAC, then narrowing to the output width.
  function automatic logic [DW-1:0] narrow(input logic signed [ACC_W-1:0] a);
`ifdef IDCT_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((longint'(1) << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - 1;
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRAC;
    if (sh > Y_MAX)      return Y_MAX[DW-1:0];
    else if (sh < Y_MIN) return Y_MIN[DW-1:0];
    else                 return sh[DW-1:0];
`else
    return a[FRAC +: DW];
`endif
  endfunction

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(DW-1));
  // Coefficients are shifted right each cycle, so bit 0 is always the current bit.
  assign addr     = {xs_q[0][0], xs_q[1][0], xs_q[2][0], xs_q[3][0]};

  for (genvar n = 0; n < 4; n++) begin : g_rom
    idct_da_rom u_rom (
      .row_i  (2'(n)),
      .addr_i (addr),
      .word_o (rom_w[n])
    );
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next state
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      acc_d[k] = acc_q[k];
      y_d[k]   = y_q[k];
    end
    if (accept) begin
      cnt_d = '0;
      for (int k = 0; k < 4; k++) acc_d[k] = '0;
    end else if (state_q == SHIFT) begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      for (int k = 0; k < 4; k++) begin
        // The MSB carries weight -2^(DW-1) in two's complement.
        if (last_bit) acc_d[k] = acc_q[k] - (sext(rom_w[k]) <<< cnt_q);
        else          acc_d[k] = acc_q[k] + (sext(rom_w[k]) <<< cnt_q);
        if (last_bit) y_d[k] = narrow(acc_d[k]);
      end
    end
  end

  // Coefficient shift registers carry no reset: they are reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      xs_q[0] <= x0;
      xs_q[1] <= x1;
      xs_q[2] <= x2;
      xs_q[3] <= x3;
    end else if (state_q == SHIFT) begin
      for (int k = 0; k < 4; k++) xs_q[k] <= xs_q[k] >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        acc_q[k] <= '0;
        y_q[k]   <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        acc_q[k] <= acc_d[k];
        y_q[k]   <= y_d[k];
      end
    end
  end

  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];

endmodule

// File: tb/tb_idct4_da.sv
module tb_idct4_da;

  localparam int DW = 16;
  localparam int M [4][4] = '{'{11585,  15137,  11585,   6269},
                              '{11585,   6269, -11585, -15137},
                              '{11585,  -6269, -11585,  15137},
                              '{11585, -15137,  11585,  -6269}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] y0, y1, y2, y3;

  idct4_da #(.DW(DW), .FRAC(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, n_out = 0, n_sent = 0;

  typedef struct {
    logic [3:0][15:0] y;
    int               ecyc;
  } exp_t;
  exp_t sb[$];

  // Reference: matrix product, floor division by 2^14, then narrowing.
  function automatic logic [15:0] ref_y(input int n, input logic [3:0][15:0] xv);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(M[n][k]) * longint'(signed'(xv[k]));
    s = s >>> 14;
`ifdef IDCT_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [15:0] a, b, c, d, output int acc_cyc);
    exp_t e;
    int   guard = 0;
    acc_cyc = -1;
    @(negedge clk);
    in_valid = 1'b1;
    x0 = a; x1 = b; x2 = c; x3 = d;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      for (int n = 0; n < 4; n++) e.y[n] = ref_y(n, {d, c, b, a});
      acc_cyc = cyc + 1;
      e.ecyc  = cyc + 1 + DW;
      sb.push_back(e);
      n_sent++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!out_valid && g < 100);
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || !in_ready) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("wait_idle", in_ready, 1);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor / scoreboard checker
  initial begin
    logic             prev_ov;
    logic [3:0][15:0] prev_y, cur;
    exp_t             e;
    prev_ov = 1'b0;
    prev_y  = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {y3, y2, y1, y0};
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else                chk("latency", cyc, sb[0].ecyc);
      end
      if (out_valid && prev_ov) chk("y_stable", longint'(cur), longint'(prev_y));
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        for (int n = 0; n < 4; n++)
          chk($sformatf("y%0d", n), signed'(cur[n]), signed'(e.y[n]));
        n_out++;
      end
      prev_ov = out_valid && !out_ready;
      prev_y  = cur;
    end
  end

  initial begin
    int ac, c, g;
    logic done;
    done = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y0", y0, 0);
    chk("rst_y1", y1, 0);
    chk("rst_y2", y2, 0);
    chk("rst_y3", y3, 0);
    rst = 1'b0;

    // Directed vectors
    send(16'd1000, 16'd0, 16'd0, 16'd0, ac);
    send(16'd0, 16'd1000, 16'd0, 16'd0, ac);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, ac);
    send(16'h8000, 16'd0, 16'd0, 16'd0, ac);
    send(16'd0, 16'd0, 16'd0, 16'd0, ac);
    wait_idle();

    // Back-pressure for 10 cycles with a competing input vector
    out_ready = 1'b0;
    send(16'd1234, 16'hFDC9, 16'd89, 16'hF448, ac);
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x0 = 16'd77; x1 = 16'hFF00; x2 = 16'd4096; x3 = 16'h8001;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    c = cyc;
    send(16'd77, 16'hFF00, 16'd4096, 16'h8001, ac);
    chk("accept_after_release", ac, c + 2);
    wait_idle();

    // Reset while processing bit 7
    send(16'd5000, 16'd3000, 16'hF000, 16'd12, ac);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_sent--;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_y0", y0, 0);
    chk("abort_y3", y3, 0);
    repeat (40) @(negedge clk);

    // Randomized traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), ac);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    g = 0;
    while (sb.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", sb.size(), 0);
    chk("out_count", n_out, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
